crc_frame_transmitter: RTL and testbench

Transmit end of the inter-node link: accepts one 64-bit payload plus source/destination addresses through a valid/ready handshake and shifts it out as a 76-bit serial frame. The frame is header, payload, then a CRC-4 computed on the fly over the payload. It feeds the receive/CRC-check fabric that delivers `DataOut` words to the addressed node, and produces exactly the data/CRC pairing that fabric checks.

---
 rtl/link_pkg.sv | 17 +
 rtl/crc_frame_transmitter_if.sv | 15 +
 rtl/crc4_serial.sv | 16 +
 rtl/crc_frame_transmitter.sv | 50 +++++
 tb/tb_crc_frame_transmitter.sv | 134 +++++++++++++
 5 files changed

// File: rtl/link_pkg.sv
// link_pkg: shared frame layout, CRC-4 parameters and transmitter state type
package link_pkg;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 4;
  localparam int CRC_W = 4;
  localparam logic [CRC_W-1:0] CRC_POLY = 4'h3;
  localparam logic [CRC_W-1:0] CRC_INIT = 4'h0;
  localparam int FRAME_LEN = 2*ADDR_W + DATA_W + CRC_W;
  localparam int SH_W = 2*ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME_LEN);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t HDR_END = cnt_t'(2*ADDR_W - 1);
  localparam cnt_t DATA_END = cnt_t'(SH_W - 1);
  localparam cnt_t DONE_CNT = cnt_t'(FRAME_LEN - 2);
  localparam cnt_t CRC_END = cnt_t'(FRAME_LEN - 1);
  typedef enum logic [1:0] {IDLE, HDR, DATA, CRC} tx_state_t;
endpackage

// File: rtl/crc_frame_transmitter_if.sv
// crc_frame_transmitter_if: request handshake and serial frame outputs
interface crc_frame_transmitter_if;
  import link_pkg::*;
  logic tx_valid;
  logic tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic [ADDR_W-1:0] tx_src;
  logic [ADDR_W-1:0] tx_dst;
  logic ser_out;
  logic ser_valid;
  logic [CRC_W-1:0] crc_last;
  logic tx_done;
  modport master (output tx_valid, tx_data, tx_src, tx_dst, input tx_ready, ser_out, ser_valid, crc_last, tx_done);
  modport slave (input tx_valid, tx_data, tx_src, tx_dst, output tx_ready, ser_out, ser_valid, crc_last, tx_done);
endinterface

// File: rtl/crc4_serial.sv
// crc4_serial: bit-serial CRC-4 LFSR, one message bit per enabled cycle
module crc4_serial
  import link_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             init,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);
  logic fb;
  assign fb = bit_in ^ crc[CRC_W-1];
  always_ff @(posedge clock)
    crc <= (reset || init) ? CRC_INIT : en ? ({crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0)) : crc;
endmodule

// File: rtl/crc_frame_transmitter.sv
// crc_frame_transmitter: serializes src, dst, payload and a running CRC-4, MSB first
module crc_frame_transmitter
  import link_pkg::*;
(
  input logic clock,
  input logic reset,
  crc_frame_transmitter_if.slave t
);
  tx_state_t state;
  cnt_t cnt;
  logic [SH_W-1:0] sh;
  logic [CRC_W-1:0] crc;
  logic accept, crc_en;
  assign t.tx_ready = state == IDLE || (state == CRC && cnt == CRC_END);
  assign accept = t.tx_valid && t.tx_ready;
  // sh[msb] is the bit about to be driven, so the CRC sees each payload bit as it enters ser_out
  assign crc_en = (state == HDR && cnt == HDR_END) || (state == DATA && cnt != DATA_END);
  crc4_serial u_crc (.clock, .reset, .init(accept), .en(crc_en), .bit_in(sh[SH_W-1]), .crc);
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      t.ser_out <= 1'b0;
      t.ser_valid <= 1'b0;
      t.tx_done <= 1'b0;
      t.crc_last <= '0;
    end else begin
      t.tx_done <= state == CRC && cnt == DONE_CNT;
      if (state == CRC && cnt == CRC_END) t.crc_last <= crc;
      if (accept) begin
        state <= HDR;
        cnt <= '0;
        sh <= {t.tx_src[ADDR_W-2:0], t.tx_dst, t.tx_data, 1'b0};
        t.ser_out <= t.tx_src[ADDR_W-1];
        t.ser_valid <= 1'b1;
      end else if (state == IDLE || cnt == CRC_END) begin
        state <= IDLE;
        cnt <= '0;
        t.ser_out <= 1'b0;
        t.ser_valid <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
        t.ser_out <= cnt == DATA_END ? crc[CRC_W-1] : sh[SH_W-1];
        sh <= cnt == DATA_END ? {crc[CRC_W-2:0], {(SH_W-CRC_W+1){1'b0}}} : sh << 1;
        state <= cnt == HDR_END ? DATA : cnt == DATA_END ? CRC : state;
      end
    end
  end
endmodule

// File: tb/tb_crc_frame_transmitter.sv
// tb_crc_frame_transmitter: randomized frames checked each cycle against a bit-queue model
module tb_crc_frame_transmitter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;

  crc_frame_transmitter_if f();
  crc_frame_transmitter dut (.clock(clock), .reset(reset), .t(f));

  function automatic logic [3:0] crc_ref(input logic [63:0] d);
    logic [67:0] r;
    r = {d, 4'b0};
    for (int i = 67; i >= 4; i--) if (r[i]) r[i-:5] = r[i-:5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [75:0] frame_ref(input logic [3:0] s, input logic [3:0] d, input logic [63:0] p);
    return {s, d, p, crc_ref(p)};
  endfunction

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
    end
  endtask

  bit q[$];
  logic [3:0] cur_crc = 4'h0;
  logic [3:0] m_crc_last = 4'h0;
  bit live = 1'b0;
  logic acc;
  logic [75:0] fr;

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      m_crc_last = 4'h0;
      live = 1'b1;
    end else begin
      acc = f.tx_valid && q.size() <= 1;
      if (q.size() == 1) m_crc_last = cur_crc;
      if (q.size() > 0) void'(q.pop_front());
      if (acc) begin
        fr = frame_ref(f.tx_src, f.tx_dst, f.tx_data);
        cur_crc = crc_ref(f.tx_data);
        for (int i = 75; i >= 0; i--) q.push_back(fr[i]);
      end
    end
  end

  always @(negedge clock) if (live) begin
    check("ser_valid", {7'b0, f.ser_valid}, {7'b0, q.size() > 0});
    check("ser_out", {7'b0, f.ser_out}, {7'b0, q.size() > 0 ? q[0] : 1'b0});
    check("tx_ready", {7'b0, f.tx_ready}, {7'b0, q.size() <= 1});
    check("tx_done", {7'b0, f.tx_done}, {7'b0, q.size() == 1});
    check("crc_last", {4'b0, f.crc_last}, {4'b0, m_crc_last});
  end

  task automatic send(input logic [63:0] d, input logic [3:0] s, input logic [3:0] t, input bit scr, input bit keep);
    int n;
    n = 0;
    f.tx_valid = 1'b1;
    f.tx_data = d;
    f.tx_src = s;
    f.tx_dst = t;
    while (f.tx_ready !== 1'b1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got ready=%b exp 1", f.tx_ready);
    end
    @(negedge clock);
    if (!keep) f.tx_valid = 1'b0;
    if (scr) begin
      f.tx_data = {$urandom, $urandom};
      f.tx_src = 4'($urandom);
      f.tx_dst = 4'($urandom);
    end
  endtask

  initial begin
    f.tx_valid = 1'b0;
    f.tx_data = '0;
    f.tx_src = '0;
    f.tx_dst = '0;
    check("pin_crc_1", {4'b0, crc_ref(64'h1)}, 8'h03);
    check("pin_crc_3", {4'b0, crc_ref(64'h3)}, 8'h05);
    check("pin_crc_2", {4'b0, crc_ref(64'h2)}, 8'h06);
    check("pin_crc_0", {4'b0, crc_ref(64'h0)}, 8'h00);
    checks++;
    if (frame_ref(4'h2, 4'h9, 64'h1) !== 76'h2900000000000000013) begin
      errors++;
      $display("FAIL pin_frame got %h exp 2900000000000000013", frame_ref(4'h2, 4'h9, 64'h1));
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    send(64'h1, 4'h2, 4'h9, 1'b0, 1'b0);
    repeat (80) @(negedge clock);
    send(64'h3, 4'h5, 4'hA, 1'b1, 1'b0);
    repeat (80) @(negedge clock);
    send(64'h2, 4'hF, 4'h0, 1'b0, 1'b0);
    repeat (80) @(negedge clock);
    send(64'h0, 4'h1, 4'h7, 1'b1, 1'b0);
    repeat (80) @(negedge clock);
    send({$urandom, $urandom}, 4'($urandom), 4'($urandom), 1'b0, 1'b1);
    send({$urandom, $urandom}, 4'($urandom), 4'($urandom), 1'b1, 1'b0);
    repeat (160) @(negedge clock);
    send(64'h0, 4'h3, 4'h4, 1'b0, 1'b0);
    repeat (80) @(negedge clock);
    send({$urandom, $urandom}, 4'($urandom), 4'($urandom), 1'b1, 1'b0);
    repeat (28) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    send(64'h1, 4'h2, 4'h9, 1'b1, 1'b0);
    repeat (80) @(negedge clock);
    for (int i = 0; i < 12; i++) begin
      send({$urandom, $urandom}, 4'($urandom), 4'($urandom), 1'($urandom), i != 11 && $urandom_range(1) == 1);
      if (!f.tx_valid) repeat ($urandom_range(3)) @(negedge clock);
    end
    repeat (160) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
